sha3_absorb_packer: RTL and testbench

- Sits between the byte-wide AXI input FIFO read side and the Keccak-f[1600] absorb datapath, in the core clock domain.
- Packs the incoming message byte stream little-endian into 64-bit lanes and tags each lane with its index in the rate block.
- Applies FIPS 202 domain suffix and pad10*1 padding, so the permutation core only XORs lanes and permutes at block_last.

---
 rtl/sha3_absorb_packer.sv | 169 ++++++++++++++++
 tb/tb_sha3_absorb_packer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_absorb_packer.sv
// Packs a byte stream little-endian into 64-bit Keccak lanes tagged with their
// rate-block index, and appends the FIPS 202 domain suffix plus pad10*1.
module sha3_absorb_packer #(
  parameter logic [7:0] SUFFIX_SHA3  = 8'h06,
  parameter logic [7:0] SUFFIX_SHAKE = 8'h1F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sel,
  input  logic [7:0]  in_data,
  input  logic        in_keep,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] lane_data,
  output logic [4:0]  lane_idx,
  output logic        block_last,
  output logic        msg_last,
  output logic        lane_valid,
  input  logic        lane_ready
);

  typedef enum logic [1:0] {IDLE, ABSORB, PAD, WAIT_LAST} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [2:0]  byte_pos_q, byte_pos_d;
  logic [4:0]  lane_cnt_q, lane_cnt_d;
  logic [63:0] lane_reg_q, lane_reg_d;
  logic        first_pad_q, first_pad_d;
  logic        lane_valid_q, lane_valid_d;
  logic [63:0] lane_data_q, lane_data_d;
  logic [4:0]  lane_idx_q, lane_idx_d;
  logic        block_last_q, block_last_d;
  logic        msg_last_q, msg_last_d;

  logic [4:0]  rate_lanes;
  logic        last_lane;
  logic        accept;
  logic        wr_en;
  logic        pad_final;
  logic [7:0]  wr_byte;

  always_comb begin
    case (sel_q)
      2'b00:   rate_lanes = 5'd17;
      2'b01:   rate_lanes = 5'd9;
      2'b10:   rate_lanes = 5'd21;
      default: rate_lanes = 5'd17;
    endcase
  end

  assign last_lane = (lane_cnt_q == rate_lanes - 5'd1);
  assign in_ready  = ((state_q == IDLE) || (state_q == ABSORB)) && !lane_valid_q;
  assign accept    = in_valid && in_ready;

  // One byte per cycle enters the lane: either a message byte or a pad byte.
  always_comb begin
    wr_en     = 1'b0;
    wr_byte   = 8'h00;
    pad_final = 1'b0;
    if (accept) begin
      wr_en   = in_keep;
      wr_byte = in_data;
    end else if ((state_q == PAD) && !lane_valid_q) begin
      wr_en     = 1'b1;
      pad_final = last_lane && (byte_pos_q == 3'd7);
      wr_byte   = (first_pad_q ? (sel_q[1] ? SUFFIX_SHAKE : SUFFIX_SHA3) : 8'h00)
                | (pad_final ? 8'h80 : 8'h00);
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    byte_pos_d   = byte_pos_q;
    lane_cnt_d   = lane_cnt_q;
    lane_reg_d   = lane_reg_q;
    first_pad_d  = first_pad_q;
    lane_valid_d = lane_valid_q;
    lane_data_d  = lane_data_q;
    lane_idx_d   = lane_idx_q;
    block_last_d = block_last_q;
    msg_last_d   = msg_last_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d       = sel;
          first_pad_d = 1'b1;
          state_d     = in_last ? PAD : ABSORB;
        end
      end
      ABSORB: begin
        if (accept && in_last) state_d = PAD;
      end
      PAD: begin
        if (wr_en) begin
          first_pad_d = 1'b0;
          if (pad_final) state_d = WAIT_LAST;
        end
      end
      WAIT_LAST: state_d = state_q;
      default:   state_d = IDLE;
    endcase

    // A completed lane moves straight to the output register so the
    // accumulator is already clear when the next byte arrives.
    if (wr_en) begin
      lane_reg_d[{byte_pos_q, 3'b000} +: 8] = wr_byte;
      if (byte_pos_q == 3'd7) begin
        lane_data_d  = lane_reg_d;
        lane_reg_d   = 64'h0;
        byte_pos_d   = 3'd0;
        lane_valid_d = 1'b1;
        lane_idx_d   = lane_cnt_q;
        block_last_d = last_lane;
        msg_last_d   = pad_final;
      end else begin
        byte_pos_d = byte_pos_q + 3'd1;
      end
    end

    if (lane_valid_q && lane_ready) begin
      lane_valid_d = 1'b0;
      lane_cnt_d   = last_lane ? 5'd0 : lane_cnt_q + 5'd1;
      if (state_q == WAIT_LAST) begin
        state_d    = IDLE;
        lane_cnt_d = 5'd0;
        byte_pos_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 2'b00;
      byte_pos_q   <= 3'd0;
      lane_cnt_q   <= 5'd0;
      lane_reg_q   <= 64'h0;
      first_pad_q  <= 1'b0;
      lane_valid_q <= 1'b0;
      lane_data_q  <= 64'h0;
      lane_idx_q   <= 5'd0;
      block_last_q <= 1'b0;
      msg_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      byte_pos_q   <= byte_pos_d;
      lane_cnt_q   <= lane_cnt_d;
      lane_reg_q   <= lane_reg_d;
      first_pad_q  <= first_pad_d;
      lane_valid_q <= lane_valid_d;
      lane_data_q  <= lane_data_d;
      lane_idx_q   <= lane_idx_d;
      block_last_q <= block_last_d;
      msg_last_q   <= msg_last_d;
    end
  end

  assign lane_valid = lane_valid_q;
  assign lane_data  = lane_data_q;
  assign lane_idx   = lane_idx_q;
  assign block_last = block_last_q;
  assign msg_last   = msg_last_q;

endmodule

// File: tb/tb_sha3_absorb_packer.sv
// Self-checking bench for sha3_absorb_packer: directed vector table, hand-written
// backpressure/reset sequences and randomized messages against a padding model.
module tb_sha3_absorb_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic [7:0]  in_data;
  logic        in_keep;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] lane_data;
  logic [4:0]  lane_idx;
  logic        block_last;
  logic        msg_last;
  logic        lane_valid;
  logic        lane_ready;

  sha3_absorb_packer dut (
    .clk(clk), .reset(reset), .sel(sel), .in_data(in_data), .in_keep(in_keep),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .lane_data(lane_data), .lane_idx(lane_idx), .block_last(block_last),
    .msg_last(msg_last), .lane_valid(lane_valid), .lane_ready(lane_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  idx;
    logic        bl;
    logic        ml;
  } lane_t;

  typedef struct {
    string       name;
    logic [1:0]  sel;
    int          len;
    bit          abc;
    int          exp_lanes;
    int          probe_a;
    logic [63:0] val_a;
    int          probe_b;
    logic [63:0] val_b;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;
  logic [7:0]  msg_q[$];
  lane_t       got_q[$];
  lane_t       exp_q[$];
  vec_t        vecs[6];

  task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: message, suffix, zero fill, 0x80 on the final rate byte, then lanes.
  function automatic void build_expected(input logic [1:0] s);
    int rl, rb, total;
    logic [7:0] pb[$];
    lane_t e;
    rl = (s == 2'd0) ? 17 : (s == 2'd1) ? 9 : (s == 2'd2) ? 21 : 17;
    rb = 8 * rl;
    total = (msg_q.size() / rb + 1) * rb;
    pb = msg_q;
    pb.push_back(s[1] ? 8'h1F : 8'h06);
    while (pb.size() < total) pb.push_back(8'h00);
    pb[total-1] = pb[total-1] | 8'h80;
    exp_q.delete();
    for (int l = 0; l < total / 8; l++) begin
      e.data = 64'h0;
      for (int k = 0; k < 8; k++) e.data[8*k +: 8] = pb[8*l + k];
      e.idx = 5'(l % rl);
      e.bl  = ((l % rl) == rl - 1);
      e.ml  = (l == total / 8 - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic send_msg(input logic [1:0] s, input bit gaps, input bit term);
    int n;
    int beats;
    int wc;
    n = msg_q.size();
    beats = (n == 0 && term) ? 1 : n;
    for (int i = 0; i < beats; i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      sel      = (i == 0) ? s : 2'($urandom);
      in_valid = 1'b1;
      in_keep  = (n != 0);
      in_data  = (n != 0) ? msg_q[i] : 8'($urandom);
      in_last  = term && (i == beats - 1);
      wc = 0;
      while (!in_ready && wc < 5000) begin
        @(negedge clk);
        wc++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("[TB] FAIL beat_accept actual=stalled expected=accepted");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_keep  = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [1:0] s, input bit gaps, input string name);
    int wc;
    got_q.delete();
    build_expected(s);
    send_msg(s, gaps, 1'b1);
    wc = 0;
    while (!(got_q.size() >= exp_q.size() && in_ready) && wc < 20000) begin
      @(negedge clk);
      wc++;
    end
    repeat (3) @(negedge clk);
    check_output({name, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_output($sformatf("%s_lane%0d", name, i), {1'b0, got_q[i]}, {1'b0, exp_q[i]});
    check_output({name, "_idle_ready"}, 72'(in_ready), 72'd1);
  endtask

  task automatic probe(input string name, input int idx, input logic [63:0] val);
    if (idx < got_q.size()) begin
      check_output($sformatf("%s_probe%0d", name, idx), 72'(got_q[idx].data), 72'(val));
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_probe%0d actual=missing expected=%h", name, idx, val);
    end
  endtask

  task automatic fill_msg(input bit abc, input int len);
    msg_q.delete();
    if (abc) begin
      msg_q.push_back(8'h61);
      msg_q.push_back(8'h62);
      msg_q.push_back(8'h63);
    end else begin
      for (int i = 0; i < len; i++) msg_q.push_back(8'(i));
    end
  endtask

  // Lane consumer: the handshake for the coming posedge is decided here, so the
  // lane recorded is exactly the one the DUT sees accepted.
  initial begin
    bit r;
    lane_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(2) != 0);
        default: r = 1'b0;
      endcase
      lane_ready = r;
      if (!reset && lane_valid && r)
        got_q.push_back('{data: lane_data, idx: lane_idx, bl: block_last, ml: msg_last});
    end
  end

  initial begin
    int wc;
    logic [1:0] s;
    int n;

    vecs[0] = '{"empty256", 2'b00, 0,   1'b0, 17, 0,  64'h06,                 16, 64'h8000_0000_0000_0000};
    vecs[1] = '{"abc256",   2'b00, 3,   1'b1, 17, 0,  64'h0000_0000_0663_6261, 16, 64'h8000_0000_0000_0000};
    vecs[2] = '{"m135",     2'b00, 135, 1'b0, 17, 0,  64'h0706_0504_0302_0100, 16, 64'h8686_8584_8382_8180};
    vecs[3] = '{"m136",     2'b00, 136, 1'b0, 34, 17, 64'h06,                 33, 64'h8000_0000_0000_0000};
    vecs[4] = '{"shake128", 2'b10, 0,   1'b0, 21, 0,  64'h1F,                 20, 64'h8000_0000_0000_0000};
    vecs[5] = '{"empty512", 2'b01, 0,   1'b0, 9,  0,  64'h06,                 8,  64'h8000_0000_0000_0000};

    reset = 1'b1; sel = 2'b00; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_lane_valid", 72'(lane_valid), 72'd0);
    check_output("rst_lane_data",  72'(lane_data),  72'd0);
    check_output("rst_lane_flags", 72'({lane_idx, block_last, msg_last}), 72'd0);
    check_output("rst_in_ready",   72'(in_ready),   72'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      ready_mode = 0;
      fill_msg(vecs[v].abc, vecs[v].len);
      apply_stimulus(vecs[v].sel, 1'b0, vecs[v].name);
      check_output({vecs[v].name, "_nlanes"}, 72'(got_q.size()), 72'(vecs[v].exp_lanes));
      probe(vecs[v].name, vecs[v].probe_a, vecs[v].val_a);
      probe(vecs[v].name, vecs[v].probe_b, vecs[v].val_b);
    end

    // Backpressure: first lane held for 5 clocks while the producer keeps offering.
    ready_mode = 2;
    fill_msg(1'b0, 30);
    got_q.delete();
    build_expected(2'b01);
    fork
      send_msg(2'b01, 1'b0, 1'b1);
      begin
        wc = 0;
        while (!lane_valid && wc < 200) begin
          @(negedge clk);
          wc++;
        end
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check_output("bp_lane_data",  72'(lane_data), 72'(exp_q[0].data));
          check_output("bp_hold_flags", 72'({lane_valid, in_ready, lane_idx}), 72'({1'b1, 1'b0, 5'd0}));
        end
        ready_mode = 0;
      end
    join
    wc = 0;
    while (!(got_q.size() >= exp_q.size() && in_ready) && wc < 20000) begin
      @(negedge clk);
      wc++;
    end
    repeat (3) @(negedge clk);
    check_output("bp_count", 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_output($sformatf("bp_lane%0d", i), {1'b0, got_q[i]}, {1'b0, exp_q[i]});

    // Reset after three bytes must discard the partial lane entirely.
    ready_mode = 0;
    msg_q.delete();
    msg_q.push_back(8'hAA); msg_q.push_back(8'hBB); msg_q.push_back(8'hCC);
    got_q.delete();
    send_msg(2'b10, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_output("mid_rst_outputs", 72'({lane_valid, lane_data, lane_idx, block_last, msg_last}), 72'd0);
    check_output("mid_rst_in_ready", 72'(in_ready), 72'd1);
    reset = 1'b0;
    @(negedge clk);
    check_output("mid_rst_no_lanes", 72'(got_q.size()), 72'd0);
    fill_msg(1'b1, 3);
    apply_stimulus(2'b00, 1'b0, "abc_after_rst");
    probe("abc_after_rst", 0, 64'h0000_0000_0663_6261);
    probe("abc_after_rst", 16, 64'h8000_0000_0000_0000);

    for (int t = 0; t < 10; t++) begin
      s = 2'($urandom);
      n = $urandom_range(0, 180);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
      ready_mode = 1;
      apply_stimulus(s, 1'b1, $sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
